// File: rtl/kiscv_pkg.sv
// Shared types for the APB load/store unit: access size, response cause,
// FSM state and the captured request control fields.
package kiscv_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    CAUSE_OK         = 2'd0,
    CAUSE_MISALIGNED = 2'd1,
    CAUSE_BUS_ERR    = 2'd2,
    CAUSE_TIMEOUT    = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  // Request control fields kept for the whole transfer
  typedef struct packed {
    logic  write;
    size_e size;
    logic  unsgn;
  } req_ctl_t;

endpackage

// File: rtl/apb_lsu_if.sv
// Request/response port plus APB master port of the load/store unit.
interface apb_lsu_if #(
  parameter int unsigned APB_paddr_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [1:0]                   req_size;
  logic                         req_unsigned;
  logic [APB_paddr_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]        req_wdata;
  logic                         rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_rdata;
  logic [1:0]                   rsp_cause;
  logic [APB_paddr_WIDTH-1:0]   APB_paddr;
  logic [DATA_WIDTH-1:0]        APB_pdata;
  logic [DATA_WIDTH-1:0]        APB_prdata;
  logic                         APB_psel;
  logic                         APB_penable;
  logic                         APB_pwrite;
  logic [DATA_WIDTH/8-1:0]      APB_pstb;
  logic                         APB_pready;
  logic                         APB_perr;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
           APB_prdata, APB_pready, APB_perr,
    output req_ready, rsp_valid, rsp_rdata, rsp_cause,
           APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
           APB_prdata, APB_pready, APB_perr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_cause,
           APB_paddr, APB_pdata, APB_psel, APB_penable, APB_pwrite, APB_pstb
  );
endinterface

// File: rtl/apb_lsu_lanes.sv
// Byte-lane steering: alignment check, write strobe/data shift on the request
// side, and read-data extraction with zero/sign extension on the response side.
module apb_lsu_lanes
  import kiscv_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BYTES      = DATA_WIDTH / 8,
  localparam int unsigned OFF_W      = $clog2(BYTES)
) (
  input  size_e                 req_size_i,
  input  logic [OFF_W-1:0]      req_off_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  size_e                 rd_size_i,
  input  logic [OFF_W-1:0]      rd_off_i,
  input  logic                  rd_unsigned_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  output logic                  misaligned_c_o,
  output logic [BYTES-1:0]      wstb_c_o,
  output logic [DATA_WIDTH-1:0] wdata_c_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o
);

  logic [7:0]            span;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign;

  // A doubleword on the narrow bus can never be issued, so it reports as misaligned
  always_comb begin
    misaligned_c_o = 1'b0;
    span           = 8'hFF;
    case (req_size_i)
      SZ_B:    begin misaligned_c_o = 1'b0;                                   span = 8'h01; end
      SZ_H:    begin misaligned_c_o = req_off_i[0];                           span = 8'h03; end
      SZ_W:    begin misaligned_c_o = |req_off_i[1:0];                        span = 8'h0F; end
      default: begin misaligned_c_o = (DATA_WIDTH != 64) || (|req_off_i);    span = 8'hFF; end
    endcase
    wstb_c_o  = req_write_i ? (span[BYTES-1:0] << req_off_i) : {BYTES{1'b1}};
    wdata_c_o = req_wdata_i << {req_off_i, 3'b000};
  end

  always_comb begin
    shifted = prdata_i >> {rd_off_i, 3'b000};
    keep    = '1;
    sign    = 1'b0;
    case (rd_size_i)
      SZ_B:    begin keep = DATA_WIDTH'(8'hFF);          sign = shifted[7];  end
      SZ_H:    begin keep = DATA_WIDTH'(16'hFFFF);       sign = shifted[15]; end
      SZ_W:    begin keep = DATA_WIDTH'(32'hFFFF_FFFF);  sign = shifted[31]; end
      default: begin keep = '1;                          sign = 1'b0;        end
    endcase
    rdata_c_o = (shifted & keep) | ({DATA_WIDTH{sign & ~rd_unsigned_i}} & ~keep);
  end

endmodule

// File: rtl/apb_lsu.sv
// APB load/store master: one request at a time, SETUP/ACCESS transfer with
// wait states and optional timeout, registered single-cycle response.
module apb_lsu
  import kiscv_pkg::*;
#(
  parameter int unsigned APB_paddr_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned TIMEOUT         = 0
) (
  input logic       clk,
  input logic       rts,
  apb_lsu_if.master bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t                 state_q, state_d;
  req_ctl_t                   ctl_q;
  logic [OFF_W-1:0]           off_q;
  logic [CNT_W-1:0]           cnt_q;
  logic                       ready_q, ready_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic                       pwrite_q;
  logic [APB_paddr_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0]      pdata_q;
  logic [BYTES-1:0]           pstb_q;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
  cause_e                     rsp_cause_q, rsp_cause_d;

  logic                       accept_c;
  logic                       expire_c;
  logic                       mis_c;
  logic [OFF_W-1:0]           req_off_c;
  logic [BYTES-1:0]           wstb_c;
  logic [DATA_WIDTH-1:0]      wdata_c;
  logic [DATA_WIDTH-1:0]      rdata_c;

  assign accept_c  = bus.req_valid && ready_q;
  assign req_off_c = bus.req_addr[OFF_W-1:0];
  // Last ACCESS cycle allowed before the transfer is abandoned
  assign expire_c  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  apb_lsu_lanes #(.DATA_WIDTH(DATA_WIDTH)) u_lanes (
    .req_size_i     (size_e'(bus.req_size)),
    .req_off_i      (req_off_c),
    .req_write_i    (bus.req_write),
    .req_wdata_i    (bus.req_wdata),
    .rd_size_i      (ctl_q.size),
    .rd_off_i       (off_q),
    .rd_unsigned_i  (ctl_q.unsgn),
    .prdata_i       (bus.APB_prdata),
    .misaligned_c_o (mis_c),
    .wstb_c_o       (wstb_c),
    .wdata_c_o      (wdata_c),
    .rdata_c_o      (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rts) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: state_d = accept_c ? (mis_c ? ST_RESP : ST_SETUP) : ST_IDLE;
      ST_SETUP:         state_d = ST_ACCESS;
      ST_ACCESS:        if (bus.APB_pready || expire_c) state_d = ST_RESP;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    ready_d     = (state_d == ST_IDLE) || (state_d == ST_RESP);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_cause_d = CAUSE_OK;
    rsp_rdata_d = '0;
    if (accept_c && mis_c) begin
      rsp_cause_d = CAUSE_MISALIGNED;
    end else if (state_q == ST_ACCESS && bus.APB_pready) begin
      if (bus.APB_perr)        rsp_cause_d = CAUSE_BUS_ERR;
      else if (!ctl_q.write)   rsp_rdata_d = rdata_c;
    end else if (state_q == ST_ACCESS && expire_c) begin
      rsp_cause_d = CAUSE_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rts) begin
      ready_q     <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      pstb_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= CAUSE_OK;
      ctl_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
    end else begin
      ready_q     <= ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_cause_q <= rsp_cause_d;
      if (accept_c) begin
        ctl_q.write <= bus.req_write;
        ctl_q.size  <= size_e'(bus.req_size);
        ctl_q.unsgn <= bus.req_unsigned;
        off_q       <= req_off_c;
        if (!mis_c) begin
          paddr_q  <= {bus.req_addr[APB_paddr_WIDTH-1:OFF_W], OFF_W'(0)};
          pwrite_q <= bus.req_write;
          pstb_q   <= wstb_c;
          pdata_q  <= wdata_c;
        end
      end
      if (state_q == ST_SETUP)       cnt_q <= '0;
      else if (state_q == ST_ACCESS) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.APB_psel    = psel_q;
  assign bus.APB_penable = penable_q;
  assign bus.APB_pwrite  = pwrite_q;
  assign bus.APB_paddr   = paddr_q;
  assign bus.APB_pdata   = pdata_q;
  assign bus.APB_pstb    = pstb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_cause   = rsp_cause_q;

endmodule

// File: tb/tb_apb_lsu.sv
// Bench for apb_lsu: a 32-bit instance with TIMEOUT=4 and a 64-bit instance
// without timeout, driven through one shared stimulus/observation mux.
module tb_apb_lsu;
  import kiscv_pkg::*;

  logic clk = 1'b0;
  logic rts;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_lsu_if #(.APB_paddr_WIDTH(32), .DATA_WIDTH(32)) if32 ();
  apb_lsu_if #(.APB_paddr_WIDTH(32), .DATA_WIDTH(64)) if64 ();

  apb_lsu #(.APB_paddr_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .rts(rts), .bus(if32.master));
  apb_lsu #(.APB_paddr_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(0)) dut64 (
    .clk(clk), .rts(rts), .bus(if64.master));

  logic        sel64;
  logic        r_valid, r_write, r_unsigned, p_ready, p_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [63:0] r_wdata, p_rdata;

  assign if32.req_valid    = r_valid & ~sel64;
  assign if64.req_valid    = r_valid & sel64;
  assign if32.req_write    = r_write;      assign if64.req_write    = r_write;
  assign if32.req_size     = r_size;       assign if64.req_size     = r_size;
  assign if32.req_unsigned = r_unsigned;   assign if64.req_unsigned = r_unsigned;
  assign if32.req_addr     = r_addr;       assign if64.req_addr     = r_addr;
  assign if32.req_wdata    = r_wdata[31:0];
  assign if64.req_wdata    = r_wdata;
  assign if32.APB_prdata   = p_rdata[31:0];
  assign if64.APB_prdata   = p_rdata;
  assign if32.APB_pready   = p_ready & ~sel64;
  assign if64.APB_pready   = p_ready & sel64;
  assign if32.APB_perr     = p_err;        assign if64.APB_perr     = p_err;

  logic        o_ready, o_rsp_valid, o_psel, o_penable, o_pwrite;
  logic [1:0]  o_cause;
  logic [31:0] o_paddr;
  logic [63:0] o_rdata, o_pdata;
  logic [7:0]  o_pstb;
  assign o_ready     = sel64 ? if64.req_ready   : if32.req_ready;
  assign o_rsp_valid = sel64 ? if64.rsp_valid   : if32.rsp_valid;
  assign o_psel      = sel64 ? if64.APB_psel    : if32.APB_psel;
  assign o_penable   = sel64 ? if64.APB_penable : if32.APB_penable;
  assign o_pwrite    = sel64 ? if64.APB_pwrite  : if32.APB_pwrite;
  assign o_cause     = sel64 ? if64.rsp_cause   : if32.rsp_cause;
  assign o_paddr     = sel64 ? if64.APB_paddr   : if32.APB_paddr;
  assign o_rdata     = sel64 ? if64.rsp_rdata   : {32'h0, if32.rsp_rdata};
  assign o_pdata     = sel64 ? if64.APB_pdata   : {32'h0, if32.APB_pdata};
  assign o_pstb      = sel64 ? if64.APB_pstb    : {4'h0, if32.APB_pstb};

  int          checks = 0;
  int          errors = 0;
  int          t1, setup_cyc, prev_setup_cyc, last_lat;
  logic [63:0] last_rdata, last_pdata;
  logic [1:0]  last_cause;
  logic [31:0] last_paddr;
  logic [7:0]  last_pstb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: byte-offset arithmetic straight from the lane rules
  function automatic void model(input int dw, input bit w, input bit [1:0] sz, input bit uns,
                                input bit [31:0] addr, input bit [63:0] wd, input bit [63:0] prd,
                                output bit mis, output bit [31:0] paddr, output bit [7:0] stb,
                                output bit [63:0] pdata, output bit [63:0] rdata);
    int nb, off, bytes, bits;
    bit [63:0] dmask, fmask, v;
    nb    = dw / 8;
    off   = int'(addr % nb);
    bytes = 1 << sz;
    bits  = 8 * bytes;
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    fmask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    mis   = (sz == 2'd3 && dw == 32) || (off % bytes != 0);
    paddr = addr - 32'(off);
    stb   = w ? 8'(((1 << bytes) - 1) << off) : 8'((1 << nb) - 1);
    pdata = (wd << (8 * off)) & dmask;
    v     = ((prd & dmask) >> (8 * off)) & fmask;
    if (!uns && bits < dw && v[bits-1]) v = v | (dmask & ~fmask);
    rdata = v;
  endfunction

  task automatic issue(input bit w, input bit [1:0] sz, input bit uns,
                       input bit [31:0] addr, input bit [63:0] wd);
    r_write = w; r_size = sz; r_unsigned = uns; r_addr = addr; r_wdata = wd;
    r_valid = 1'b1;
    chk("req_ready", o_ready, 1);
    @(posedge clk); #1;
    r_valid = 1'b0;
    t1 = cyc;
  endtask

  // Runs from the cycle after accept to the response cycle, acting as slave
  task automatic finish(input bit w, input bit [1:0] sz, input bit uns, input bit [31:0] addr,
                        input bit [63:0] wd, input bit [63:0] prd, input int waits, input bit perr);
    bit mis;
    bit [31:0] ea;
    bit [7:0]  es;
    bit [63:0] ed, er;
    model(sel64 ? 64 : 32, w, sz, uns, addr, wd, prd, mis, ea, es, ed, er);
    if (mis) begin
      chk("mis_psel", o_psel, 0);
      chk("mis_valid", o_rsp_valid, 1);
      chk("mis_cause", o_cause, 1);
      chk("mis_rdata", o_rdata, 0);
      last_cause = o_cause;
      last_lat   = cyc - t1 + 1;
      return;
    end
    chk("setup_psel", o_psel, 1);
    chk("setup_penable", o_penable, 0);
    chk("setup_paddr", o_paddr, ea);
    chk("setup_pwrite", o_pwrite, w);
    chk("setup_pstb", o_pstb, es);
    if (w) chk("setup_pdata", o_pdata, ed);
    last_paddr = o_paddr; last_pstb = o_pstb; last_pdata = o_pdata;
    prev_setup_cyc = setup_cyc;
    setup_cyc      = cyc;
    @(posedge clk); #1;
    for (int k = 0; k <= waits; k++) begin
      chk("acc_psel", o_psel, 1);
      chk("acc_penable", o_penable, 1);
      chk("acc_paddr_hold", o_paddr, ea);
      chk("acc_pwrite_hold", o_pwrite, w);
      chk("acc_no_rsp", o_rsp_valid, 0);
      if (k == waits) begin p_ready = 1'b1; p_err = perr; p_rdata = prd; end
      @(posedge clk); #1;
      p_ready = 1'b0; p_err = 1'b0; p_rdata = {$urandom, $urandom};
    end
    chk("rsp_valid", o_rsp_valid, 1);
    chk("rsp_cause", o_cause, perr ? 2 : 0);
    chk("rsp_rdata", o_rdata, (perr || w) ? 64'd0 : er);
    chk("rsp_psel", o_psel, 0);
    chk("rsp_penable", o_penable, 0);
    chk("rsp_ready", o_ready, 1);
    last_rdata = o_rdata;
    last_cause = o_cause;
    last_lat   = cyc - t1 + 1;
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk("idle_valid", o_rsp_valid, 0);
    chk("idle_cause", o_cause, 0);
    chk("idle_rdata", o_rdata, 0);
    chk("idle_psel", o_psel, 0);
    chk("idle_ready", o_ready, 1);
  endtask

  task automatic rand_run(input int n, input int maxw);
    bit w, uns, perr;
    bit [1:0] sz;
    bit [31:0] addr;
    bit [63:0] wd, prd;
    int waits;
    for (int i = 0; i < n; i++) begin
      w    = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << sz) - 32'd1);
      wd    = {$urandom, $urandom};
      prd   = {$urandom, $urandom};
      waits = $urandom_range(0, maxw);
      perr  = ($urandom_range(0, 7) == 0);
      issue(w, sz, uns, addr, wd);
      finish(w, sz, uns, addr, wd, prd, waits, perr);
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    idle_step();
  endtask

  initial begin
    sel64 = 1'b0; rts = 1'b1;
    r_valid = 1'b0; r_write = 1'b0; r_unsigned = 1'b0; r_size = 2'd0;
    r_addr = '0; r_wdata = '0; p_rdata = '0; p_ready = 1'b0; p_err = 1'b0;
    setup_cyc = 0; prev_setup_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      chk("rst_psel", o_psel, 0);
      chk("rst_penable", o_penable, 0);
      chk("rst_pwrite", o_pwrite, 0);
      chk("rst_paddr", o_paddr, 0);
      chk("rst_pdata", o_pdata, 0);
      chk("rst_pstb", o_pstb, 0);
      chk("rst_valid", o_rsp_valid, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_cause", o_cause, 0);
    end
    sel64 = 1'b0;
    rts   = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", o_ready, 1);

    // Signed byte load from the top lane
    issue(0, 2'd0, 0, 32'h8000_0003, 0);
    finish(0, 2'd0, 0, 32'h8000_0003, 0, 64'h8012_3456, 0, 0);
    chk("lb_value", last_rdata, 64'h0000_0000_FFFF_FF80);
    chk("lb_latency", last_lat, 3);
    idle_step();

    // Halfword store into the upper lanes
    issue(1, 2'd1, 0, 32'h8000_0002, 64'hBEEF);
    finish(1, 2'd1, 0, 32'h8000_0002, 64'hBEEF, 0, 1, 0);
    chk("sh_paddr", last_paddr, 32'h8000_0000);
    chk("sh_pstb", last_pstb, 8'b1100);
    chk("sh_pdata", last_pdata, 64'hBEEF_0000);
    idle_step();

    // Misaligned word and illegal doubleword
    issue(0, 2'd2, 0, 32'h8000_0001, 0);
    finish(0, 2'd2, 0, 32'h8000_0001, 0, 0, 0, 0);
    chk("lw_mis_cause", last_cause, 1);
    chk("lw_mis_latency", last_lat, 1);
    idle_step();
    issue(1, 2'd3, 0, 32'h8000_0000, 64'h1122_3344_5566_7788);
    finish(1, 2'd3, 0, 32'h8000_0000, 64'h1122_3344_5566_7788, 0, 0, 0);
    chk("sd32_cause", last_cause, 1);
    idle_step();

    // Three wait states then a slave error
    issue(0, 2'd2, 0, 32'h8000_0040, 0);
    finish(0, 2'd2, 0, 32'h8000_0040, 0, 64'hDEAD_BEEF, 3, 1);
    chk("perr_latency", last_lat, 6);
    chk("perr_cause", last_cause, 2);
    idle_step();

    // Timeout after four ACCESS cycles, late pready ignored
    issue(0, 2'd2, 0, 32'h8000_0080, 0);
    chk("to_setup", o_penable, 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("to_access_psel", o_psel, 1);
      chk("to_no_rsp", o_rsp_valid, 0);
    end
    @(posedge clk); #1;
    chk("to_psel_drop", o_psel, 0);
    chk("to_valid", o_rsp_valid, 1);
    chk("to_cause", o_cause, 3);
    chk("to_rdata", o_rdata, 0);
    p_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("to_late_no_rsp", o_rsp_valid, 0);
      chk("to_late_psel", o_psel, 0);
    end
    p_ready = 1'b0;

    // Reset pulsed during ACCESS aborts silently
    issue(0, 2'd2, 0, 32'h8000_0010, 0);
    @(posedge clk); #1;
    chk("abort_in_access", o_penable, 1);
    rts = 1'b1;
    @(posedge clk); #1;
    chk("abort_psel", o_psel, 0);
    chk("abort_penable", o_penable, 0);
    chk("abort_valid", o_rsp_valid, 0);
    rts = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_rsp", o_rsp_valid, 0);
    chk("abort_ready", o_ready, 1);

    // Back-to-back accept in the response cycle
    issue(0, 2'd2, 0, 32'h8000_0020, 0);
    finish(0, 2'd2, 0, 32'h8000_0020, 0, 64'h0BAD_F00D, 0, 0);
    issue(1, 2'd2, 0, 32'h8000_0024, 64'h1234_5678);
    finish(1, 2'd2, 0, 32'h8000_0024, 64'h1234_5678, 0, 0, 0);
    chk("b2b_interval", setup_cyc - prev_setup_cyc, 3);
    idle_step();

    rand_run(40, 3);

    // Wide bus
    sel64 = 1'b1;
    #1;
    chk("w64_idle_ready", o_ready, 1);
    issue(0, 2'd2, 1, 32'h8000_0004, 0);
    finish(0, 2'd2, 1, 32'h8000_0004, 0, 64'h89AB_CDEF_0000_0000, 0, 0);
    chk("lwu64_value", last_rdata, 64'h0000_0000_89AB_CDEF);
    idle_step();
    issue(0, 2'd2, 0, 32'h8000_0004, 0);
    finish(0, 2'd2, 0, 32'h8000_0004, 0, 64'h89AB_CDEF_0000_0000, 0, 0);
    chk("lw64_value", last_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    idle_step();

    rand_run(40, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
